// File: rtl/id_ctrl_stage.sv
// -----------------------------------------------------------------------------
// id_ctrl_stage
//   Decode/control stage directly behind instruction fetch. Holds the IF/ID
//   instruction register, decodes it for the datapath, resolves branches
//   through a small target LUT and feeds Branch/Target/Halt back to fetch.
//   A one-cycle bubble follows every taken branch (the PC+1 word is dropped).
//   Retired instructions are counted per program (cleared on start).
//
// Ports
//   CLK          clock, all state on posedge
//   Reset_n      synchronous active-low reset (overrides start)
//   start        program (re)start pulse, same one fetch receives
//   instruction  9-bit fetched word
//   Zero         datapath zero flag, used combinationally by BR-cond
//   lut_we/lut_addr/lut_data   branch-target LUT write port
//   Branch/Target/Halt         combinational control back to fetch
//   id_valid     decoded fields describe a real instruction
//   alu_op/ra/rb raw instruction fields
//   reg_we/mem_re/mem_we       decoded enables, zero unless a valid RUN word
//   retire_cnt   retired instruction count (wraps)
// -----------------------------------------------------------------------------
module id_ctrl_stage #(
  parameter int TGT_W     = 8,
  parameter int LUT_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [8:0]       instruction,
  input  logic             Zero,
  input  logic             lut_we,
  input  logic [2:0]       lut_addr,
  input  logic [TGT_W-1:0] lut_data,
  output logic             Branch,
  output logic [TGT_W-1:0] Target,
  output logic             Halt,
  output logic             id_valid,
  output logic [2:0]       alu_op,
  output logic [2:0]       ra,
  output logic [2:0]       rb,
  output logic             reg_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FLUSH  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [8:0]       ir;
  logic             valid;
  logic [CNT_W-1:0] cnt;
  logic [TGT_W-1:0] lut [LUT_DEPTH];

  logic             run_valid;
  logic             taken;
  logic             is_halt;

  // LUT depths below 8 fold the 3-bit index back into range
  function automatic logic [2:0] lut_idx(input logic [2:0] a);
    lut_idx = 3'(32'(a) % 32'(LUT_DEPTH));
  endfunction

  // branch / halt resolution from the registered word
  always_comb begin
    run_valid = (state == RUN) && valid;
    taken     = run_valid && (ir[8:6] == 3'b110) && (!ir[5] || Zero);
    is_halt   = run_valid && (ir[8:6] == 3'b111) && (ir[5:3] == 3'b000);
  end

  // control outputs to fetch; Target only shows a value while Branch is high
  always_comb begin
    Branch = taken;
    Halt   = is_halt || (state == HALTED);
    if (taken) begin
      Target = lut[lut_idx(ir[2:0])];
    end else begin
      Target = '0;
    end
  end

  // datapath decode; enables are suppressed for bubbles and outside RUN
  always_comb begin
    id_valid   = valid;
    alu_op     = ir[8:6];
    ra         = ir[5:3];
    rb         = ir[2:0];
    retire_cnt = cnt;
    reg_we     = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    if (run_valid) begin
      case (ir[8:6])
        3'b000, 3'b001, 3'b010, 3'b011: reg_we = 1'b1;
        3'b100: begin
          mem_re = 1'b1;
          reg_we = 1'b1;
        end
        3'b101:  mem_we = 1'b1;
        default: reg_we = 1'b0;
      endcase
    end else begin
      reg_we = 1'b0;
    end
  end

  // next-state logic; start wins over branch and halt
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = RUN;
    end else begin
      case (state)
        IDLE: state_nx = IDLE;
        RUN: begin
          if (taken) begin
            state_nx = FLUSH;
          end else if (is_halt) begin
            state_nx = HALTED;
          end else begin
            state_nx = RUN;
          end
        end
        FLUSH:   state_nx = RUN;
        HALTED:  state_nx = HALTED;
        default: state_nx = IDLE;
      endcase
    end
  end

  // state, IF/ID register and retire counter
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state <= IDLE;
      ir    <= 9'd0;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        // restart: first captured word is a bubble
        ir    <= instruction;
        valid <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          RUN: begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, valid};
            if (is_halt) begin
              // ir frozen on the HALT word
              valid <= 1'b0;
            end else begin
              ir    <= instruction;
              // the word behind a taken branch is dropped
              valid <= !taken;
            end
          end
          FLUSH: begin
            ir    <= instruction;
            valid <= 1'b1;
          end
          default: valid <= 1'b0;
        endcase
      end
    end
  end

  // branch-target LUT; a same-cycle read sees the old contents
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut[i] <= '0;
      end
    end else if (lut_we) begin
      lut[lut_idx(lut_addr)] <= lut_data;
    end
  end

endmodule

// File: tb/tb_id_ctrl_stage.sv
module tb_id_ctrl_stage;

  logic       CLK = 1'b0;
  logic       Reset_n, start, Zero, lut_we;
  logic [8:0] instruction;
  logic [2:0] lut_addr;
  logic [7:0] lut_data;

  logic        Branch, Halt, id_valid, reg_we, mem_re, mem_we;
  logic [7:0]  Target;
  logic [2:0]  alu_op, ra, rb;
  logic [15:0] retire_cnt;

  logic        Branch4, Halt4, id_valid4, reg_we4, mem_re4, mem_we4;
  logic [7:0]  Target4;
  logic [2:0]  alu_op4, ra4, rb4;
  logic [3:0]  retire_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [42:0] exp_q [$];
  logic [42:0] msk_q [$];
  string       nam_q [$];

  localparam logic [8:0] ADD   = 9'b000_001_010;
  localparam logic [8:0] LOAD  = 9'b100_011_100;
  localparam logic [8:0] STORE = 9'b101_101_110;
  localparam logic [8:0] BR2   = 9'b110_000_010;
  localparam logic [8:0] BRC2  = 9'b110_100_010;
  localparam logic [8:0] BR3   = 9'b110_000_011;
  localparam logic [8:0] XOR1  = 9'b011_110_001;
  localparam logic [8:0] SUB1  = 9'b001_010_011;
  localparam logic [8:0] AND1  = 9'b010_000_001;
  localparam logic [8:0] AND2  = 9'b010_101_101;
  localparam logic [8:0] HALTW = 9'b111_000_000;
  localparam logic [8:0] PC1W  = 9'b000_111_111;

  id_ctrl_stage #(.TGT_W(8), .LUT_DEPTH(8), .CNT_W(16)) u_dut (
    .CLK(CLK), .Reset_n(Reset_n), .start(start), .instruction(instruction),
    .Zero(Zero), .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
    .Branch(Branch), .Target(Target), .Halt(Halt), .id_valid(id_valid),
    .alu_op(alu_op), .ra(ra), .rb(rb), .reg_we(reg_we), .mem_re(mem_re),
    .mem_we(mem_we), .retire_cnt(retire_cnt)
  );

  id_ctrl_stage #(.TGT_W(8), .LUT_DEPTH(8), .CNT_W(4)) u_dut4 (
    .CLK(CLK), .Reset_n(Reset_n), .start(start), .instruction(instruction),
    .Zero(Zero), .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
    .Branch(Branch4), .Target(Target4), .Halt(Halt4), .id_valid(id_valid4),
    .alu_op(alu_op4), .ra(ra4), .rb(rb4), .reg_we(reg_we4), .mem_re(mem_re4),
    .mem_we(mem_we4), .retire_cnt(retire_cnt4)
  );

  always #5 CLK = ~CLK;

  // expected output vector; en = {reg_we, mem_re, mem_we}; 4-bit counter is cnt mod 16
  function automatic logic [42:0] mk(input logic br, input logic [7:0] tgt,
                                     input logic hlt, input logic vld,
                                     input logic [8:0] w, input logic [2:0] en,
                                     input int cnt);
    logic [15:0] c16;
    c16 = 16'(cnt);
    mk = {br, tgt, hlt, vld, w, en, c16, c16[3:0]};
  endfunction

  logic [42:0] M_ALL, M_NOIR;

  // drive one cycle of inputs and queue what the DUT must show during it
  task automatic cyc(input logic rst, input logic st, input logic [8:0] ins,
                     input logic z, input string nm,
                     input logic [42:0] e, input logic [42:0] m);
    Reset_n     = rst;
    start       = st;
    instruction = ins;
    Zero        = z;
    exp_q.push_back(e);
    msk_q.push_back(m);
    nam_q.push_back(nm);
    @(posedge CLK);
    #2;
    lut_we = 1'b0;
  endtask

  // monitor: compare queued expectation against outputs mid-cycle
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [42:0] act, e, m;
      string nm;
      act = {Branch, Target, Halt, id_valid, alu_op, ra, rb,
             reg_we, mem_re, mem_we, retire_cnt, retire_cnt4};
      e  = exp_q.pop_front();
      m  = msk_q.pop_front();
      nm = nam_q.pop_front();
      n_checks++;
      if ((act & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (mask %h)", nm, act, e, m);
      end
    end
  end

  initial begin
    M_ALL  = '1;
    M_NOIR = ~mk(1'b0, 8'h00, 1'b0, 1'b0, 9'h1FF, 3'b000, 0);
    Reset_n = 1'b0; start = 1'b1; instruction = 9'd0; Zero = 1'b0;
    lut_we = 1'b0; lut_addr = 3'd0; lut_data = 8'h00;
    @(posedge CLK); #2;

    // reset overrides start, then idle without start
    cyc(1'b0, 1'b1, 9'd0, 1'b0, "reset1", mk(0, 8'h00, 0, 0, 9'd0, 3'b000, 0), M_ALL);
    cyc(1'b0, 1'b1, 9'd0, 1'b0, "reset2", mk(0, 8'h00, 0, 0, 9'd0, 3'b000, 0), M_ALL);
    cyc(1'b1, 1'b0, ADD,  1'b0, "idle1",  mk(0, 8'h00, 0, 0, 9'd0, 3'b000, 0), M_ALL);
    cyc(1'b1, 1'b0, ADD,  1'b0, "idle2",  mk(0, 8'h00, 0, 0, 9'd0, 3'b000, 0), M_ALL);
    cyc(1'b1, 1'b1, 9'd0, 1'b0, "idle_start", mk(0, 8'h00, 0, 0, 9'd0, 3'b000, 0), M_ALL);
    cyc(1'b1, 1'b0, ADD,  1'b0, "bubble", mk(0, 8'h00, 0, 0, 9'd0, 3'b000, 0), M_NOIR);
    lut_we = 1'b1; lut_addr = 3'd2; lut_data = 8'h40;
    cyc(1'b1, 1'b0, LOAD,  1'b0, "add",   mk(0, 8'h00, 0, 1, ADD,   3'b100, 0), M_ALL);
    cyc(1'b1, 1'b0, STORE, 1'b0, "load",  mk(0, 8'h00, 0, 1, LOAD,  3'b110, 1), M_ALL);
    cyc(1'b1, 1'b0, BR2,   1'b0, "store", mk(0, 8'h00, 0, 1, STORE, 3'b001, 2), M_ALL);
    // taken branch; a write to the same index this cycle must not show yet
    lut_we = 1'b1; lut_addr = 3'd2; lut_data = 8'h55;
    cyc(1'b1, 1'b0, PC1W, 1'b0, "br_taken", mk(1, 8'h40, 0, 1, BR2, 3'b000, 3), M_ALL);
    cyc(1'b1, 1'b0, XOR1, 1'b0, "flush",    mk(0, 8'h00, 0, 0, 9'd0, 3'b000, 4), M_NOIR);
    cyc(1'b1, 1'b0, BRC2, 1'b0, "tgt_word", mk(0, 8'h00, 0, 1, XOR1, 3'b100, 4), M_ALL);
    cyc(1'b1, 1'b0, SUB1, 1'b0, "brc_untaken", mk(0, 8'h00, 0, 1, BRC2, 3'b000, 5), M_ALL);
    cyc(1'b1, 1'b0, BRC2, 1'b0, "no_bubble",   mk(0, 8'h00, 0, 1, SUB1, 3'b100, 6), M_ALL);
    cyc(1'b1, 1'b0, AND1, 1'b1, "brc_taken",   mk(1, 8'h55, 0, 1, BRC2, 3'b000, 7), M_ALL);
    cyc(1'b1, 1'b0, AND2, 1'b0, "flush2",      mk(0, 8'h00, 0, 0, 9'd0, 3'b000, 8), M_NOIR);
    cyc(1'b1, 1'b0, HALTW, 1'b0, "and",        mk(0, 8'h00, 0, 1, AND2, 3'b100, 8), M_ALL);
    cyc(1'b1, 1'b0, ADD,  1'b0, "halt",        mk(0, 8'h00, 1, 1, HALTW, 3'b000, 9), M_ALL);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, ADD, 1'(i), "halted", mk(0, 8'h00, 1, 0, HALTW, 3'b000, 10), M_ALL);
    end
    cyc(1'b1, 1'b1, ADD,  1'b0, "halted_start", mk(0, 8'h00, 1, 0, HALTW, 3'b000, 10), M_ALL);
    cyc(1'b1, 1'b0, ADD,  1'b0, "restart",      mk(0, 8'h00, 0, 0, 9'd0, 3'b000, 0), M_NOIR);
    cyc(1'b1, 1'b0, BR2,  1'b0, "add2",         mk(0, 8'h00, 0, 1, ADD, 3'b100, 0), M_ALL);
    cyc(1'b1, 1'b0, ADD,  1'b0, "br2",          mk(1, 8'h55, 0, 1, BR2, 3'b000, 1), M_ALL);
    // reset while flushing
    cyc(1'b0, 1'b0, ADD,  1'b0, "flush_rst",    mk(0, 8'h00, 0, 0, 9'd0, 3'b000, 2), M_NOIR);
    cyc(1'b1, 1'b0, ADD,  1'b0, "after_rst",    mk(0, 8'h00, 0, 0, 9'd0, 3'b000, 0), M_ALL);
    // counter wrap on the 4-bit instance
    cyc(1'b1, 1'b1, 9'd0, 1'b0, "start3",       mk(0, 8'h00, 0, 0, 9'd0, 3'b000, 0), M_ALL);
    cyc(1'b1, 1'b0, ADD,  1'b0, "bubble3",      mk(0, 8'h00, 0, 0, 9'd0, 3'b000, 0), M_NOIR);
    for (int k = 0; k < 17; k++) begin
      cyc(1'b1, 1'b0, ADD, 1'b0, "add_run", mk(0, 8'h00, 0, 1, ADD, 3'b100, k), M_ALL);
    end
    lut_we = 1'b1; lut_addr = 3'd3; lut_data = 8'hA5;
    cyc(1'b1, 1'b0, BR3,  1'b0, "wrap",         mk(0, 8'h00, 0, 1, ADD, 3'b100, 17), M_ALL);
    // start beats a taken branch: no flush, counter cleared
    cyc(1'b1, 1'b1, ADD,  1'b0, "br_start",     mk(1, 8'hA5, 0, 1, BR3, 3'b000, 18), M_ALL);
    cyc(1'b1, 1'b0, ADD,  1'b0, "start_bubble", mk(0, 8'h00, 0, 0, 9'd0, 3'b000, 0), M_NOIR);
    cyc(1'b1, 1'b0, 9'd0, 1'b0, "start_run",    mk(0, 8'h00, 0, 1, ADD, 3'b100, 0), M_ALL);

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
      @(posedge CLK);
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
